// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the instruction memory read address,
// absorbs the one-cycle read latency and hands {pc, inst} pairs to decode via a 2-entry buffer.
module inst_fetch #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] mem_addr_r,
    input  logic [31:0]       mem_data_out,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc
);

    // Handshake: an instruction transfers on every rising edge where
    // inst_valid && inst_ready; the head stays stable while inst_valid && !inst_ready.

    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;

    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_data [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occ;
    logic        w_issue;

    assign w_pop  = inst_valid && inst_ready;
    assign w_push = r_inflight;

    // Occupancy the buffer will see once the current in-flight word lands;
    // a new issue is only allowed when that still leaves room for it.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = fetch_en && !redirect_valid && (w_occ < 3'd2);

    assign mem_addr_r = r_fetch_pc[ADDR_W+1:2];
    assign inst_valid = (r_count != 2'd0);
    assign inst_data  = r_buf_data[r_rd_ptr];
    assign inst_pc    = r_buf_pc[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_buf_pc[0]   <= 32'h0;
            r_buf_pc[1]   <= 32'h0;
            r_buf_data[0] <= 32'h0;
            r_buf_data[1] <= 32'h0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else if (redirect_valid) begin
            // Buffered and in-flight words belong to the abandoned path.
            r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            r_inflight <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_buf_pc[r_wr_ptr]   <= r_inflight_pc;
                r_buf_data[r_wr_ptr] <= mem_data_out;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model with mem[i] = i + 0x100,
// expected {pc, inst} stream held in a queue and compared at every transfer.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [9:0]  mem_addr_r;
    logic [31:0] mem_data_out;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    inst_fetch #(.ADDR_W(10), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_addr_r     (mem_addr_r),
        .mem_data_out   (mem_data_out),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    // 1K x 32 memory with registered read, contents mem[i] = i + 0x100.
    always @(posedge clk) begin
        mem_data_out <= 32'h100 + {22'b0, mem_addr_r};
    end

    // Scoreboard: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got pc=%h data=%h, required no transfer", inst_pc, inst_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({inst_pc, inst_data} !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_stream: got pc=%h data=%h, required pc=%h data=%h",
                             inst_pc, inst_data, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic push_seq(input logic [31:0] start_pc, input int n);
        logic [31:0] pc;
        pc = start_pc;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({pc, 32'h100 + {22'b0, pc[11:2]}});
            pc = pc + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b, required 0", inst_valid);
        end
        checks++;
        if (inst_pc !== 32'h0 || inst_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_head: got pc=%h data=%h, required 0/0", inst_pc, inst_data);
        end
        checks++;
        if (mem_addr_r !== 10'd0) begin
            failures++;
            $display("FAIL reset_addr: got %h, required 000", mem_addr_r);
        end
    endtask

    // Releases reset and checks the two-cycle fetch-to-decode latency.
    task automatic test_start(input string tag);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        exp_q.delete();
        push_seq(32'h0, 60);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== (c >= 2)) begin
                failures++;
                $display("FAIL %s_valid_c%0d: got %b, required %b", tag, c, inst_valid, (c >= 2));
            end
            if (c == 2) begin
                checks++;
                if (inst_pc !== 32'h0) begin
                    failures++;
                    $display("FAIL %s_first_pc: got %h, required 00000000", tag, inst_pc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (inst_valid && inst_pc == 32'hC) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL bp_reach_pc: got no head pc 0000000c, required it within 50 cycles");
        end
        step();
        inst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || mem_addr_r !== 10'd6) begin
                failures++;
                $display("FAIL bp_hold_c%0d: got valid=%b pc=%h addr=%h, required 1/00000010/006",
                         c, inst_valid, inst_pc, mem_addr_r);
            end
        end
        step();
        inst_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_resume_gap_c%0d: got valid=%b, required 1", c, inst_valid);
            end
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL rd_pre_valid: got %b, required 1", inst_valid);
        end
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        inst_ready     = 1'b0;
        exp_q.delete();
        push_seq(32'h200, 40);
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== (c == 3)) begin
                failures++;
                $display("FAIL rd_valid_r%0d: got %b, required %b", c, inst_valid, (c == 3));
            end
        end
        checks++;
        if (inst_pc !== 32'h200 || inst_data !== 32'h180) begin
            failures++;
            $display("FAIL rd_target: got pc=%h data=%h, required 00000200/00000180", inst_pc, inst_data);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] wrap_pc[4];
        logic [31:0] wrap_data[4];
        wrap_pc   = '{32'hFF8, 32'hFFC, 32'h1000, 32'h1004};
        wrap_data = '{32'h4FE, 32'h4FF, 32'h100, 32'h101};
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFF8;
        @(negedge clk);
        #1;
        exp_q.delete();
        push_seq(32'hFF8, 40);
        step();
        redirect_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== wrap_pc[c-3] || inst_data !== wrap_data[c-3]) begin
                    failures++;
                    $display("FAIL wrap_r%0d: got valid=%b pc=%h data=%h, required 1/%h/%h",
                             c, inst_valid, inst_pc, inst_data, wrap_pc[c-3], wrap_data[c-3]);
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fetch_en();
        bit exp_v[6];
        int p0;
        exp_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        p0 = pops;
        step();
        fetch_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== exp_v[c]) begin
                failures++;
                $display("FAIL fen_valid_c%0d: got %b, required %b", c, inst_valid, exp_v[c]);
            end
            if (c == 2) begin
                @(posedge clk);
                #1;
                fetch_en = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pops - p0 != 6) begin
            failures++;
            $display("FAIL fen_count: got %0d transfers, required 6", pops - p0);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0 || mem_addr_r !== 10'd0) begin
            failures++;
            $display("FAIL rst_mid: got valid=%b pc=%h data=%h addr=%h, required 0/0/0/0",
                     inst_valid, inst_pc, inst_data, mem_addr_r);
        end
        repeat (2) @(negedge clk);
        test_start("rst_mid_restart");
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_start("start");
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fetch_en();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
